// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider.
// State encoding and iteration sizing.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int ITERS     = DIV_WIDTH;
  localparam int CNT_W     = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    HALT  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor for one restoring step.
// borrow_o is the sign bit of the (W+1)-bit difference.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int W = DIV_WIDTH
) (
  input  logic [W:0] a_i,
  input  logic [W:0] b_i,
  output logic [W:0] diff_o,
  output logic       borrow_o
);

  assign diff_o   = a_i - b_i;
  assign borrow_o = diff_o[W];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider.
// One shift cycle and one trial-subtract cycle per quotient bit.
module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e     state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0] diff;
  logic           borrow;

  div_trial_sub #(.W(WIDTH)) u_sub (
    .a_i      (r_q),
    .b_i      ({1'b0, d_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  // Next-state and datapath update for each FSM state
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          q_d     = Din;
          r_d     = '0;
          cnt_d   = '0;
          dbz_d   = (d_q == '0);
          state_d = SHIFT;
        end else if (ClearA_LoadB) begin
          d_d = Din;
          r_d = '0;
        end
      end
      SHIFT: begin
        r_d     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        q_d     = {q_q[WIDTH-2:0], 1'b0};
        state_d = SUB;
      end
      SUB: begin
        if (!borrow) begin
          r_d    = diff;
          q_d[0] = 1'b1;
        end
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? HALT : SHIFT;
      end
      HALT: begin
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Quotient  = q_q;
  assign Remainder = r_q[WIDTH-1:0];
  assign Divisor   = d_q;
  assign Busy      = (state_q == SHIFT) || (state_q == SUB);
  assign Done      = (state_q == HALT);
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider.
// Inputs change and outputs are sampled on the falling edge.
module tb_restoring_divider;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic [7:0] Din = '0;
  logic [7:0] Quotient, Remainder, Divisor;
  logic       Busy, Done, DivByZero;

  int errors = 0;
  int checks = 0;

  restoring_divider #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .Din          (Din),
    .Quotient     (Quotient),
    .Remainder    (Remainder),
    .Divisor      (Divisor),
    .Busy         (Busy),
    .Done         (Done),
    .DivByZero    (DivByZero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic load(input logic [7:0] d);
    Din = d;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    chk("load_d", Divisor, d);
  endtask

  task automatic run_div(input string tag, input logic [7:0] x,
                         input int eq, input int er, input int ez,
                         input logic ld);
    int n;
    int busy_n;
    Din = x;
    Run = 1'b1;
    ClearA_LoadB = ld;
    tick();
    ClearA_LoadB = 1'b0;
    n = 0;
    busy_n = 0;
    while (!Done && n < 40) begin
      if (Busy) busy_n++;
      tick();
      n++;
    end
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_busy"}, busy_n, 16);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_z"}, DivByZero, ez);
    Run = 1'b0;
    tick();
    chk({tag, "_idle"}, Done, 0);
    chk({tag, "_keep"}, Quotient, eq);
  endtask

  initial begin
    int busy_n;
    repeat (3) tick();
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_d", Divisor, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_z", DivByZero, 0);
    Reset = 1'b0;
    tick();

    load(8'd7);
    run_div("d100_7", 8'd100, 14, 2, 0, 1'b0);
    load(8'd1);
    run_div("d255_1", 8'd255, 255, 0, 0, 1'b0);
    load(8'd9);
    run_div("d5_9", 8'd5, 0, 5, 0, 1'b0);
    load(8'd0);
    run_div("d200_0", 8'd200, 255, 200, 1, 1'b0);
    load(8'd7);
    run_div("d100_7b", 8'd100, 14, 2, 0, 1'b0);

    // Run held for 40 cycles: one division only
    Din = 8'd100;
    Run = 1'b1;
    busy_n = 0;
    repeat (40) begin
      tick();
      if (Busy) busy_n++;
    end
    chk("hold_busy", busy_n, 16);
    chk("hold_done", Done, 1);
    chk("hold_q", Quotient, 14);
    Run = 1'b0;
    tick();
    load(8'd3);
    run_div("d10_3", 8'd10, 3, 1, 0, 1'b0);

    // Reset in the middle of a division
    load(8'd5);
    Din = 8'd50;
    Run = 1'b1;
    repeat (7) tick();
    chk("mid_busy", Busy, 1);
    Run = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mr_busy", Busy, 0);
    chk("mr_done", Done, 0);
    chk("mr_q", Quotient, 0);
    chk("mr_r", Remainder, 0);
    chk("mr_d", Divisor, 0);
    chk("mr_z", DivByZero, 0);

    // Load pulse while busy is ignored
    load(8'd4);
    Din = 8'd20;
    Run = 1'b1;
    repeat (3) tick();
    Din = 8'd9;
    ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    chk("busy_ld_d", Divisor, 4);
    repeat (20) tick();
    chk("busy_ld_q", Quotient, 5);
    chk("busy_ld_r", Remainder, 0);
    Run = 1'b0;
    tick();

    // Run and load together: run wins
    run_div("both", 8'd30, 7, 2, 0, 1'b1);
    chk("both_d", Divisor, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider: the inverse of the lab's shift-add multiplier, on the same switch/button front end. Divisor is loaded from the switches with ClearA_LoadB. Run latches the dividend from the switches and performs one shift/trial-subtract iteration pair per bit. The block then holds quotient and remainder for the hex displays until Run is released.

## Interface
- WIDTH, 8, operand width in bits; quotient, remainder and divisor are all WIDTH bits.
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high; clock Clk.
- Run  in  1  level; starts a division when high in IDLE.
- ClearA_LoadB  in  1  level; in IDLE loads Din into divisor register and clears remainder register.
- Din  in  WIDTH  switch operand (divisor on load, dividend on Run).
- Quotient  out  WIDTH  quotient register (Q).
- Remainder  out  WIDTH  remainder register (R, low WIDTH bits).
- Divisor  out  WIDTH  divisor register (D).
- Busy  out  1  high in SHIFT and SUB.
- Done  out  1  high in HALT.
- DivByZero  out  1  latched at start: D==0.

## Operation
- Registers: R (WIDTH+1 bits), Q (WIDTH), D (WIDTH), iteration counter cnt (log2(WIDTH)+1 bits), DivByZero flag, state.
- States: IDLE, SHIFT, SUB, HALT.
- IDLE, Run=1: Q<=Din, R<=0, cnt<=0, DivByZero<=(D==0); go to SHIFT. Run has priority over ClearA_LoadB in the same cycle.
- IDLE, Run=0, ClearA_LoadB=1: D<=Din, R<=0. Q is unchanged.
- IDLE, both inputs low: stay; all registers hold.
- SHIFT: {R,Q}<={R,Q}<<1 with 0 shifted into Q[0]; go to SUB.
- SUB: diff=R-{1'b0,D} (WIDTH+1 bits). If diff[WIDTH]==0, R<=diff and Q[0]<=1; else R and Q unchanged (restore). cnt<=cnt+1. If cnt==WIDTH-1, go to HALT; else go to SHIFT.
- HALT: registers hold. Run=1 stays in HALT, so a held Run yields exactly one division. Run=0 goes to IDLE, and results stay visible.
- Divide by zero: no special path; the iterations run normally and give Q=all-ones and R=dividend, and DivByZero=1. The flag holds until the next start or Reset.
- ClearA_LoadB outside IDLE is ignored.
- Reset (any state, including mid-division): state<=IDLE; R, Q, D, cnt, DivByZero <= 0.

## Timing
- Reset values: Quotient=0, Remainder=0, Divisor=0, Busy=0, Done=0, DivByZero=0.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Latency: Run sampled at edge t0 (IDLE→SHIFT); 2·WIDTH further edges (t1..t16 for WIDTH=8) complete the iterations. Done=1 and results are final after edge t16; Busy=1 from after t0 through t16 exclusive.
- Leaving HALT: one edge after Run is sampled low, the state is IDLE; a new Run is accepted at the following edge at the earliest.
- Remainder output = R[WIDTH-1:0]. R[WIDTH] is 0 outside SHIFT→SUB transit.

## Structure
- Package div_pkg: state enum typedef (IDLE, SHIFT, SUB, HALT), localparam ITERS=WIDTH default, counter width constant.
- Sub-module div_trial_sub: combinational (WIDTH+1)-bit subtractor returning diff and borrow (diff[WIDTH]). It is instantiated once by the FSM/datapath top.
- Top holds FSM (always_ff state plus always_comb next-state/outputs) and datapath registers.

## Test plan
- Load D=7, Run with Din=100 → after 16 cycles Done=1, Quotient=14, Remainder=2, DivByZero=0; Busy high exactly 16 cycles.
- Load D=1, Din=255 → Quotient=255, Remainder=0. Load D=9, Din=5 → Quotient=0, Remainder=5.
- Load D=0, Din=200 → Quotient=255, Remainder=200, DivByZero=1; next division 100/7 clears the flag.
- Run held high for 40 cycles → exactly one division and the state stays HALT. Drop Run, reload D=3, Run with Din=10 → Quotient=3, Remainder=1.
- Reset asserted at cycle 7 of a division → next cycle state is IDLE and all outputs are 0; ClearA_LoadB pulsed while Busy → D unchanged.
- Run and ClearA_LoadB both high in IDLE → division starts with the old D and Din as dividend; D not reloaded.
